// File: rtl/usb_phy_pkg.sv
// rtl/usb_phy_pkg.sv - shared state encoding and default timing for the USB 2.0 bus-event sequencer
// Defaults assume a 60 MHz UTMI clock.
package usb_phy_pkg;

  typedef enum logic [2:0] {
    FS_IDLE,
    RST_DET,
    RST_HOLD,
    CHIRP_K,
    CHIRP_WAIT,
    HS_ACT,
    HS_REVERT,
    SUSPEND
  } chirp_state_e;

  localparam int DEF_CNT_W     = 18;
  localparam int DEF_T_RST_DET = 150;
  localparam int DEF_T_CHIRP_K = 60000;
  localparam int DEF_T_FILT    = 150;
  localparam int DEF_T_WTFS    = 120000;
  localparam int DEF_T_HS_IDLE = 180000;
  localparam int DEF_T_REVERT  = 6000;
  localparam int DEF_T_SUSP    = 180000;

endpackage

// File: rtl/chirp_run_filter.sv
// rtl/chirp_run_filter.sv - consecutive-level run counter with a one-cycle done pulse
// o_done fires on the THRESH-th consecutive cycle of i_level; the run then restarts from zero.
module chirp_run_filter #(
  parameter int THRESH = 150,
  parameter int W      = $clog2(THRESH + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_level,
  output logic o_done
);

  logic [W-1:0] cnt;

  assign o_done = !i_clr && i_level && (cnt == W'(THRESH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_clr || !i_level || o_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hs_chirp_controller.sv
// rtl/hs_chirp_controller.sv - device-side bus reset qualification, HS chirp handshake and HS idle revert
// HS_CHIRP_SUSPEND_EN adds FS J-idle suspend detection and the SUSPEND state.
module hs_chirp_controller
  import usb_phy_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_RST_DET = DEF_T_RST_DET,
  parameter int T_CHIRP_K = DEF_T_CHIRP_K,
  parameter int T_FILT    = DEF_T_FILT,
  parameter int T_WTFS    = DEF_T_WTFS,
  parameter int T_HS_IDLE = DEF_T_HS_IDLE,
  parameter int T_REVERT  = DEF_T_REVERT
`ifdef HS_CHIRP_SUSPEND_EN
  ,
  parameter int T_SUSP    = DEF_T_SUSP
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_se0,
  input  logic i_j_state,
  input  logic i_k_state,
  input  logic i_squelch,
  input  logic i_hs_en,
  output logic o_hs_mode,
  output logic o_term_sel,
  output logic o_chirp_k,
  output logic o_bus_reset,
  output logic o_hs_dev,
  output logic o_suspend
);

  chirp_state_e state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d, tmr_inc;
  logic [1:0] pairs_q, pairs_d;
  logic exp_k_q, exp_k_d;
  logic hs_dev_q, hs_dev_d;
  logic bus_reset_d;
  logic resume_q, resume_d;
  logic flt_done;

  assign tmr_inc  = (&tmr_q) ? tmr_q : tmr_q + CNT_W'(1);
  assign o_hs_dev = hs_dev_q;

  chirp_run_filter #(
    .THRESH (T_FILT)
  ) u_flt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state_q != CHIRP_WAIT),
    .i_level (exp_k_q ? i_k_state : i_j_state),
    .o_done  (flt_done)
  );

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_inc;
    pairs_d     = pairs_q;
    exp_k_d     = exp_k_q;
    hs_dev_d    = hs_dev_q;
    bus_reset_d = 1'b0;
    resume_d    = 1'b0;
    case (state_q)
      FS_IDLE: begin
`ifdef HS_CHIRP_SUSPEND_EN
        tmr_d = i_j_state ? tmr_inc : '0;
        if (i_se0) state_d = RST_DET;
        else if (i_j_state && tmr_q == CNT_W'(T_SUSP - 1)) state_d = SUSPEND;
`else
        tmr_d = '0;
        if (i_se0) state_d = RST_DET;
`endif
      end
      RST_DET: begin
        if (!i_se0) begin
          state_d = FS_IDLE;
        end else if (tmr_q == CNT_W'(T_RST_DET - 1)) begin
          bus_reset_d = 1'b1;
          hs_dev_d    = 1'b0;
          state_d     = i_hs_en ? CHIRP_K : RST_HOLD;
        end
      end
      RST_HOLD: if (!i_se0) state_d = FS_IDLE;
      CHIRP_K: begin
        // Arm the host KJ tracker so CHIRP_WAIT starts clean.
        pairs_d = '0;
        exp_k_d = 1'b1;
        if (tmr_q == CNT_W'(T_CHIRP_K - 1)) state_d = CHIRP_WAIT;
      end
      CHIRP_WAIT: begin
        if (flt_done) begin
          exp_k_d = !exp_k_q;
          if (!exp_k_q) pairs_d = pairs_q + 2'd1;
        end
        // A pair completing on the timeout cycle still wins.
        if (flt_done && !exp_k_q && pairs_q == 2'd2) begin
          state_d  = HS_ACT;
          hs_dev_d = 1'b1;
        end else if (tmr_q == CNT_W'(T_WTFS - 1)) begin
          state_d = FS_IDLE;
        end
      end
      HS_ACT: begin
        tmr_d = i_squelch ? tmr_inc : '0;
        if (i_squelch && tmr_q == CNT_W'(T_HS_IDLE - 1)) state_d = HS_REVERT;
      end
      HS_REVERT: begin
        if (tmr_q == CNT_W'(T_REVERT - 1)) begin
`ifdef HS_CHIRP_SUSPEND_EN
          state_d = i_se0 ? RST_DET : SUSPEND;
`else
          state_d = i_se0 ? RST_DET : HS_ACT;
`endif
        end
      end
`ifdef HS_CHIRP_SUSPEND_EN
      SUSPEND: begin
        resume_d = resume_q || i_k_state;
        if (i_se0) state_d = RST_DET;
        else if (resume_q && !i_k_state) state_d = hs_dev_q ? HS_ACT : FS_IDLE;
      end
`endif
      default: state_d = FS_IDLE;
    endcase
    if (state_d != state_q) tmr_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= FS_IDLE;
      tmr_q       <= '0;
      pairs_q     <= '0;
      exp_k_q     <= 1'b1;
      hs_dev_q    <= 1'b0;
      o_hs_mode   <= 1'b0;
      o_term_sel  <= 1'b1;
      o_chirp_k   <= 1'b0;
      o_bus_reset <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pairs_q     <= pairs_d;
      exp_k_q     <= exp_k_d;
      hs_dev_q    <= hs_dev_d;
      o_hs_mode   <= (state_d == HS_ACT);
      o_term_sel  <= (state_d != HS_ACT);
      o_chirp_k   <= (state_d == CHIRP_K);
      o_bus_reset <= bus_reset_d;
    end
  end

`ifdef HS_CHIRP_SUSPEND_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resume_q  <= 1'b0;
      o_suspend <= 1'b0;
    end else begin
      resume_q  <= resume_d;
      o_suspend <= (state_d == SUSPEND);
    end
  end
`else
  assign resume_q  = resume_d;
  assign o_suspend = 1'b0;
`endif

endmodule

// File: tb/tb_hs_chirp_controller.sv
// tb/tb_hs_chirp_controller.sv - scoreboard bench for hs_chirp_controller with shortened timing
// Suspend scenarios are exercised when HS_CHIRP_SUSPEND_EN is defined.
module tb_hs_chirp_controller;

  localparam int T_RST_DET = 4;
  localparam int T_CHIRP_K = 10;
  localparam int T_FILT    = 3;
  localparam int T_WTFS    = 40;
  localparam int T_HS_IDLE = 20;
  localparam int T_REVERT  = 5;
  localparam int T_SUSP    = 20;

  // {hs_mode, term_sel, chirp_k, bus_reset, hs_dev, suspend}
  localparam logic [5:0] V_FS        = 6'b010000;
  localparam logic [5:0] V_HS        = 6'b100010;
  localparam logic [5:0] V_CHIRP_RST = 6'b011100;
  localparam logic [5:0] V_REV_HD    = 6'b010010;
  localparam logic [5:0] V_SUSP_HD   = 6'b010011;
  localparam logic [5:0] V_SUSP_FS   = 6'b010001;

  localparam logic [1:0] L_SE0 = 2'd0;
  localparam logic [1:0] L_J   = 2'd1;
  localparam logic [1:0] L_K   = 2'd2;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic i_clk, i_rst_n, i_se0, i_j_state, i_k_state, i_squelch, i_hs_en;
  logic o_hs_mode, o_term_sel, o_chirp_k, o_bus_reset, o_hs_dev, o_suspend;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rst_pulses = 0;
  int   chirp_cyc = 0;

  hs_chirp_controller #(
    .CNT_W     (18),
    .T_RST_DET (T_RST_DET),
    .T_CHIRP_K (T_CHIRP_K),
    .T_FILT    (T_FILT),
    .T_WTFS    (T_WTFS),
    .T_HS_IDLE (T_HS_IDLE),
    .T_REVERT  (T_REVERT)
`ifdef HS_CHIRP_SUSPEND_EN
    ,
    .T_SUSP    (T_SUSP)
`endif
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_se0       (i_se0),
    .i_j_state   (i_j_state),
    .i_k_state   (i_k_state),
    .i_squelch   (i_squelch),
    .i_hs_en     (i_hs_en),
    .o_hs_mode   (o_hs_mode),
    .o_term_sel  (o_term_sel),
    .o_chirp_k   (o_chirp_k),
    .o_bus_reset (o_bus_reset),
    .o_hs_dev    (o_hs_dev),
    .o_suspend   (o_suspend)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_bus_reset === 1'b1) rst_pulses++;
    if (o_chirp_k === 1'b1) chirp_cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] outs();
    return {26'd0, o_hs_mode, o_term_sel, o_chirp_k, o_bus_reset, o_hs_dev, o_suspend};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic set_line(input logic [1:0] l);
    i_se0     = (l == L_SE0);
    i_j_state = (l == L_J);
    i_k_state = (l == L_K);
  endtask

  // Bus reset with HS enabled, then 3 host KJ pairs; reports outputs at the reset pulse and just before HS.
  task automatic go_hs(output bit ok, output logic [31:0] at_pulse, output logic [31:0] pre);
    int n;
    ok = 1'b1;
    pre = '0;
    i_hs_en = 1'b1;
    i_squelch = 1'b0;
    set_line(L_SE0);
    n = 0;
    while (o_bus_reset !== 1'b1 && n < 20) begin cyc(1); n++; end
    if (o_bus_reset !== 1'b1) ok = 1'b0;
    at_pulse = outs();
    n = 0;
    while (o_chirp_k === 1'b1 && n < 30) begin cyc(1); n++; end
    if (o_chirp_k !== 1'b0) ok = 1'b0;
    for (int p = 0; p < 18; p++) begin
      set_line((p % 6) < 3 ? L_K : L_J);
      cyc(1);
      if (p == 16) pre = outs();
    end
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] got;
    exp_q.push_back('{name: "reset_outputs", val: 32'(V_FS)});
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
  endtask

  task automatic test_short_se0();
    exp_t e; logic [31:0] got; int r0;
    r0 = rst_pulses;
    set_line(L_SE0);
    exp_q.push_back('{name: "short_se0_no_reset", val: 32'd0});
    exp_q.push_back('{name: "short_se0_fs_idle", val: 32'(V_FS)});
    cyc(3);
    set_line(L_J);
    cyc(5);
    got = 32'(rst_pulses - r0); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
  endtask

  task automatic test_hs_handshake();
    exp_t e; logic [31:0] got, atp, pre; bit ok; int r0, c0;
    r0 = rst_pulses; c0 = chirp_cyc;
    exp_q.push_back('{name: "handshake_waits_bounded", val: 32'd1});
    exp_q.push_back('{name: "bus_reset_starts_chirp", val: 32'(V_CHIRP_RST)});
    exp_q.push_back('{name: "not_hs_before_third_j", val: 32'(V_FS)});
    exp_q.push_back('{name: "hs_after_third_j", val: 32'(V_HS)});
    exp_q.push_back('{name: "single_bus_reset", val: 32'd1});
    exp_q.push_back('{name: "chirp_k_length", val: 32'(T_CHIRP_K)});
    go_hs(ok, atp, pre);
    got = 32'(ok); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    got = atp; e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    got = pre; e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    got = 32'(rst_pulses - r0); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    got = 32'(chirp_cyc - c0); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
  endtask

  task automatic test_hs_idle_revert();
    exp_t e; logic [31:0] got; int n;
    set_line(L_SE0);
    i_squelch = 1'b1;
    exp_q.push_back('{name: "hs_held_until_squelch_limit", val: 32'(V_HS)});
    exp_q.push_back('{name: "hs_revert_outputs", val: 32'(V_REV_HD)});
    exp_q.push_back('{name: "revert_se0_reset_latency", val: 32'(T_REVERT + T_RST_DET)});
    exp_q.push_back('{name: "revert_reset_outputs", val: 32'(V_CHIRP_RST)});
    cyc(T_HS_IDLE - 1);
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    cyc(1);
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    i_squelch = 1'b0;
    n = 0;
    while (o_bus_reset !== 1'b1 && n < 20) begin cyc(1); n++; end
    got = 32'(n); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
  endtask

  task automatic test_chirp_timeout();
    exp_t e; logic [31:0] got; int n;
    exp_q.push_back('{name: "chirp_ends_bounded", val: 32'd0});
    exp_q.push_back('{name: "timeout_to_fs_idle", val: 32'(V_FS)});
    exp_q.push_back('{name: "late_kj_ignored", val: 32'(V_FS)});
    n = 0;
    while (o_chirp_k === 1'b1 && n < 30) begin cyc(1); n++; end
    got = 32'(o_chirp_k); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    for (int c = 0; c < T_WTFS + 5; c++) begin
      set_line((c % 3) < 2 ? L_K : L_J);
      cyc(1);
    end
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    for (int p = 0; p < 18; p++) begin
      set_line((p % 6) < 3 ? L_K : L_J);
      cyc(1);
    end
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
  endtask

  task automatic test_hs_en_off();
    exp_t e; logic [31:0] got; int r0, c0;
    r0 = rst_pulses; c0 = chirp_cyc;
    i_hs_en = 1'b0;
    set_line(L_SE0);
    exp_q.push_back('{name: "fs_only_one_reset", val: 32'd1});
    exp_q.push_back('{name: "fs_only_no_chirp", val: 32'd0});
    exp_q.push_back('{name: "fs_only_hold_outputs", val: 32'(V_FS)});
    exp_q.push_back('{name: "hold_released_by_j", val: 32'd2});
    cyc(30);
    got = 32'(rst_pulses - r0); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    got = 32'(chirp_cyc - c0); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    set_line(L_J);
    cyc(2);
    set_line(L_SE0);
    cyc(8);
    got = 32'(rst_pulses - r0); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    set_line(L_J);
    cyc(2);
  endtask

  task automatic test_async_reset_chirp();
    exp_t e; logic [31:0] got; int n;
    i_hs_en = 1'b1;
    set_line(L_SE0);
    exp_q.push_back('{name: "chirp_active_before_abort", val: 32'd1});
    exp_q.push_back('{name: "async_abort_outputs", val: 32'(V_FS)});
    n = 0;
    while (o_bus_reset !== 1'b1 && n < 20) begin cyc(1); n++; end
    cyc(3);
    got = 32'(o_chirp_k); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    #2 i_rst_n = 1'b0;
    #1;
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    cyc(2);
    set_line(L_J);
    i_rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_revert_line_idle();
    exp_t e; logic [31:0] got, atp, pre; bit ok;
    exp_q.push_back('{name: "second_handshake_ok", val: 32'd1});
    exp_q.push_back('{name: "revert_before_sample", val: 32'(V_REV_HD)});
`ifdef HS_CHIRP_SUSPEND_EN
    exp_q.push_back('{name: "revert_j_to_suspend", val: 32'(V_SUSP_HD)});
    exp_q.push_back('{name: "suspend_held_during_k", val: 32'(V_SUSP_HD)});
    exp_q.push_back('{name: "resume_to_hs", val: 32'(V_HS)});
`else
    exp_q.push_back('{name: "revert_j_back_to_hs", val: 32'(V_HS)});
`endif
    go_hs(ok, atp, pre);
    got = 32'(ok && o_hs_mode === 1'b1); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    set_line(L_J);
    i_squelch = 1'b1;
    cyc(T_HS_IDLE);
    i_squelch = 1'b0;
    cyc(T_REVERT - 1);
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    cyc(1);
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
`ifdef HS_CHIRP_SUSPEND_EN
    set_line(L_K);
    cyc(3);
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    set_line(L_J);
    cyc(1);
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
`endif
  endtask

`ifdef HS_CHIRP_SUSPEND_EN
  task automatic test_fs_suspend();
    exp_t e; logic [31:0] got;
    i_rst_n = 1'b0;
    set_line(L_J);
    cyc(1);
    i_rst_n = 1'b1;
    exp_q.push_back('{name: "fs_j_before_suspend", val: 32'(V_FS)});
    exp_q.push_back('{name: "fs_j_idle_suspend", val: 32'(V_SUSP_FS)});
    exp_q.push_back('{name: "fs_resume_to_idle", val: 32'(V_FS)});
    cyc(T_SUSP - 1);
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    cyc(1);
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
    set_line(L_K);
    cyc(2);
    set_line(L_J);
    cyc(1);
    got = outs(); e = exp_q.pop_front(); n_cmp++;
    if (got !== e.val) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, got, e.val); end
  endtask
`endif

  initial begin
    i_rst_n   = 1'b0;
    i_hs_en   = 1'b1;
    i_squelch = 1'b0;
    set_line(L_J);
    cyc(3);
    i_rst_n = 1'b1;
    cyc(2);
    test_reset();
    test_short_se0();
    test_hs_handshake();
    test_hs_idle_revert();
    test_chirp_timeout();
    test_hs_en_off();
    test_async_reset_chirp();
    test_revert_line_idle();
`ifdef HS_CHIRP_SUSPEND_EN
    test_fs_suspend();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
